// File: rtl/heading_err_gen.sv
// Heading-error generator: measured minus desired heading, wrapped mod 4096,
// saturated to 10 bits and issued with a one-cycle valid strobe. A small
// settle FSM raises at_hdng once the error stays within AT_THRESH for
// SETTLE_CNT consecutive accepted samples.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | not moving; outputs flushed, counter cleared
//   TRACK   | moving, counting consecutive in-threshold samples
//   SETTLED | moving, error has stayed small long enough; at_hdng=1
module heading_err_gen #(
    parameter logic [9:0] AT_THRESH  = 10'd24,
    parameter int          SETTLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        moving,
    input  logic [11:0] hdng,
    input  logic        hdng_vld,
    input  logic [11:0] dsrd_hdng,
    output logic [9:0]  err_sat,
    output logic        err_vld,
    output logic        at_hdng
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        SETTLED = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CNT);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [9:0]  sat_nxt;
    logic        vld_nxt;
    logic [11:0] dsrd_prev;
    logic [11:0] raw;
    logic [9:0]  sat;
    logic [10:0] mag;
    logic        in_thr;
    logic        accept;
    logic        dchg;

    // Wrapped difference: 12-bit truncation gives the shortest signed angle.
    assign raw    = hdng - dsrd_hdng;
    assign accept = hdng_vld & moving;
    assign dchg   = (dsrd_hdng != dsrd_prev);

    // Clamp the 12-bit error into the signed 10-bit range and take its magnitude.
    always_comb begin
        sat = raw[9:0];
        if (!raw[11] && (raw[10:9] != 2'b00)) begin
            sat = 10'h1FF;
        end else if (raw[11] && (raw[10:9] != 2'b11)) begin
            sat = 10'h200;
        end
        // 11-bit magnitude so that -512 maps to 512 without overflow
        mag    = sat[9] ? (~{1'b1, sat} + 11'd1) : {1'b0, sat};
        in_thr = (mag <= {1'b0, AT_THRESH});
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sat_nxt   = err_sat;
        vld_nxt   = 1'b0;
        if (!moving) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            sat_nxt   = 10'd0;
        end else begin
            if (state == IDLE) begin
                state_nxt = TRACK;
            end
            if (accept) begin
                sat_nxt = sat;
                vld_nxt = 1'b1;
            end
            // A setpoint change restarts settling; a coincident sample is
            // still output but does not count toward settle.
            if (dchg && (state != IDLE)) begin
                state_nxt = TRACK;
                cnt_nxt   = 4'd0;
            end else if (accept) begin
                if (in_thr) begin
                    if (cnt < SETTLE) begin
                        cnt_nxt = cnt + 4'd1;
                    end
                    state_nxt = (cnt_nxt >= SETTLE) ? SETTLED : TRACK;
                end else begin
                    cnt_nxt   = 4'd0;
                    state_nxt = TRACK;
                end
            end
        end
    end

    // State, counter, output and setpoint-history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            err_sat   <= 10'd0;
            err_vld   <= 1'b0;
            dsrd_prev <= 12'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            err_sat   <= sat_nxt;
            err_vld   <= vld_nxt;
            dsrd_prev <= dsrd_hdng;
        end
    end

    assign at_hdng = (state == SETTLED);

endmodule

// File: tb/tb_heading_err_gen.sv
// Directed bench for heading_err_gen with hand-computed expected values.
module tb_heading_err_gen;

    logic        clk;
    logic        rst;
    logic        moving;
    logic [11:0] hdng;
    logic        hdng_vld;
    logic [11:0] dsrd_hdng;
    logic [9:0]  err_sat;
    logic        err_vld;
    logic        at_hdng;

    int total = 0;
    int bad   = 0;

    heading_err_gen dut (
        .clk       (clk),
        .rst       (rst),
        .moving    (moving),
        .hdng      (hdng),
        .hdng_vld  (hdng_vld),
        .dsrd_hdng (dsrd_hdng),
        .err_sat   (err_sat),
        .err_vld   (err_vld),
        .at_hdng   (at_hdng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One strobe: drive at negedge, sample 1 time unit after the next posedge.
    task automatic strobe(input int h, input int d);
        @(negedge clk);
        hdng      = 12'(h);
        dsrd_hdng = 12'(d);
        hdng_vld  = 1'b1;
        @(posedge clk);
        #1;
        hdng_vld  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int vld, input int err, input int at);
        chk({tag, ".vld"}, int'(err_vld), vld);
        chk({tag, ".err"}, int'($signed(err_sat)), err);
        chk({tag, ".at"},  int'(at_hdng), at);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        hdng_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e3[4];
        int e4[7];
        e3 = '{10, -5, 24, 0};
        e4 = '{3, 3, 30, 3, 3, 3, 3};

        rst = 1'b1; moving = 1'b0; hdng = '0; hdng_vld = 1'b0; dsrd_hdng = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // moving and hdng_vld rise together -> err_vld next cycle
        @(negedge clk);
        moving = 1'b1; hdng = 12'd100; dsrd_hdng = 12'd0; hdng_vld = 1'b1;
        @(posedge clk);
        #1;
        hdng_vld = 1'b0;
        chk_out("first100", 1, 100, 0);
        idle_cycle();
        chk_out("hold100", 0, 100, 0);

        strobe(700, 0);
        chk_out("sat_pos", 1, 511, 0);
        strobe(-900, 0);
        chk_out("sat_neg", 1, -512, 0);
        strobe(12'h7FF, 12'h801);
        chk_out("wrap", 1, -2, 0);

        // setpoint back to 0 with no sample; clears any count
        @(negedge clk);
        dsrd_hdng = 12'd0;
        idle_cycle();

        // settle: 10,-5,24,0
        for (int i = 0; i < 4; i++) begin
            strobe(e3[i], 0);
            chk_out($sformatf("settle%0d", i), 1, e3[i], (i == 3) ? 1 : 0);
        end
        strobe(25, 0);
        chk_out("unsettle25", 1, 25, 0);

        // interrupted settle
        for (int i = 0; i < 7; i++) begin
            strobe(e4[i], 0);
            chk_out($sformatf("intr%0d", i), 1, e4[i], (i == 6) ? 1 : 0);
        end

        // setpoint change while settled, coincident sample not counted
        strobe(60, 50);
        chk_out("dchg", 1, 10, 0);
        for (int i = 0; i < 4; i++) begin
            strobe(50, 50);
            chk_out($sformatf("post_dchg%0d", i), 1, 0, (i == 3) ? 1 : 0);
        end

        // back-to-back strobes
        @(negedge clk);
        hdng = 12'd7; hdng_vld = 1'b1;
        @(posedge clk);
        #1;
        chk_out("b2b_a", 1, -43, 0);
        @(negedge clk);
        hdng = 12'd9;
        @(posedge clk);
        #1;
        hdng_vld = 1'b0;
        chk_out("b2b_b", 1, -41, 0);

        // idle with strobes ignored
        @(negedge clk);
        moving = 1'b0; dsrd_hdng = 12'd0;
        strobe(100, 0);
        chk_out("idle_a", 0, 0, 0);
        strobe(200, 0);
        chk_out("idle_b", 0, 0, 0);

        // settle again, then async reset mid-stream
        @(negedge clk);
        moving = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobe(5, 0);
        end
        chk_out("pre_rst", 1, 5, 1);
        #1;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        strobe(100, 0);
        chk_out("post_rst", 1, 100, 0);
        idle_cycle();
        chk("post_rst.one_pulse", int'(err_vld), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
